// File: rtl/prio_irq_if.sv
// prio_irq_if -- request/grant bundle for prio_irq_ctrl.
//
// Signals (N request channels, W-bit grant code):
//   I       [N-1:0]  active-low request lines            (master -> slave)
//   mask    [N-1:0]  active-high per-channel grant mask  (master -> slave)
//   ack              acknowledge of the current grant    (master -> slave)
//   Y       [W-1:0]  registered code of granted channel  (slave -> master)
//   valid            Y holds an unacknowledged grant     (slave -> master)
//   pending [N-1:0]  registered pending-request vector   (slave -> master)
interface prio_irq_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] I;
  logic [N-1:0] mask;
  logic         ack;
  logic [W-1:0] Y;
  logic         valid;
  logic [N-1:0] pending;

  modport master (output I, mask, ack, input Y, valid, pending);
  modport slave  (input I, mask, ack, output Y, valid, pending);
endinterface

// File: rtl/prio_irq_ctrl.sv
// prio_irq_ctrl -- edge-triggered priority interrupt controller.
//
// Falling edges on the active-low request lines set per-channel pending
// bits. When idle, the highest-index unmasked pending channel is granted:
// its code is presented on Y with valid high and held until ack. The ack
// clears that channel's pending bit; a new falling edge on the same edge
// wins over the clear.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  prio_irq_if.slave (I, mask, ack in; Y, valid, pending out)
//
// Build option: define PRIO_IRQ_ROUND_ROBIN_EN to replace fixed priority
// with a downward round-robin search starting just below the last
// acknowledged channel (rr_ptr). Without the macro rr_ptr does not exist.
module prio_irq_ctrl #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic      clk,
  input  logic      rst,
  prio_irq_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] i_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] fall, elig, clr;
  logic [W-1:0] y_q, y_d, sel;
  logic         valid_q, valid_d;
  logic         armed_q;
  logic         any_elig;
`ifdef PRIO_IRQ_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr, rr_d;
`endif

`ifdef PRIO_IRQ_ROUND_ROBIN_EN
  // Search downward from ptr-1, wrapping 0 -> N-1; ptr itself is last.
  function automatic logic [W-1:0] pick(input logic [N-1:0] e,
                                        input logic [W-1:0] ptr);
    logic [W-1:0] r;
    logic         found;
    int           idx;
    r     = '0;
    found = 1'b0;
    for (int d = 1; d <= N; d++) begin
      idx = (int'(ptr) + N - d) % N;
      if (!found && e[idx]) begin
        r     = W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction
`else
  // Fixed priority: the highest set index wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] e);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (e[k]) r = W'(k);
    end
    return r;
  endfunction
`endif

  // The first edge after reset only loads i_q from the live lines, so a
  // line already held low at release is not mistaken for a falling edge.
  assign fall     = armed_q ? (i_q & ~bus.I) : '0;
  assign elig     = pend_q & ~bus.mask;
  assign any_elig = |elig;

`ifdef PRIO_IRQ_ROUND_ROBIN_EN
  assign sel = pick(elig, rr_ptr);
`else
  assign sel = pick(elig);
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    clr     = '0;
`ifdef PRIO_IRQ_ROUND_ROBIN_EN
    rr_d    = rr_ptr;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (any_elig) begin
          y_d     = sel;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Y stays frozen here regardless of I, mask or pending.
        if (bus.ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          for (int k = 0; k < N; k++) begin
            if (y_q == W'(k)) clr[k] = 1'b1;
          end
`ifdef PRIO_IRQ_ROUND_ROBIN_EN
          rr_d = y_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // New capture ORed after the clear so a same-edge re-request survives.
    pend_d = (pend_q & ~clr) | fall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      i_q     <= '1;
      armed_q <= 1'b0;
`ifdef PRIO_IRQ_ROUND_ROBIN_EN
      rr_ptr  <= W'(N - 1);
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      i_q     <= bus.I;
      armed_q <= 1'b1;
`ifdef PRIO_IRQ_ROUND_ROBIN_EN
      rr_ptr  <= rr_d;
`endif
    end
  end

  assign bus.Y       = y_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pend_q;

endmodule
